// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: round-robin sharing of one byte-oriented SPI controller
// between NUM_REQUESTERS masters. A grant is held (with chip-select kept
// asserted) across a burst until the owner marks its last byte or drops its
// request; bursts are separated by a fixed CS-deasserted gap.
module spi_bus_arbiter #(
   parameter int NUM_REQUESTERS = 2,
   parameter int CS_INDEX_WIDTH = 1,
   parameter int GAP_CYCLES     = 2
) (
   input  logic                                     clock,
   input  logic                                     reset,
   input  logic [NUM_REQUESTERS-1:0]                req,
   input  logic [NUM_REQUESTERS-1:0]                req_last,
   input  logic [8*NUM_REQUESTERS-1:0]              req_tx_data,
   input  logic [CS_INDEX_WIDTH*NUM_REQUESTERS-1:0] req_cs_index,
   output logic [NUM_REQUESTERS-1:0]                grant,
   output logic [NUM_REQUESTERS-1:0]                ack,
   output logic [7:0]                               rx_data,
   output logic                                     spi_start,
   output logic [7:0]                               spi_tx_data,
   output logic [CS_INDEX_WIDTH-1:0]                spi_cs_index,
   output logic                                     spi_cs_hold,
   input  logic                                     spi_busy,
   input  logic                                     spi_done,
   input  logic [7:0]                               spi_rx_data
);

   localparam int IDX_W = $clog2(NUM_REQUESTERS);
   localparam int GAP_W = 4;
   localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NUM_REQUESTERS - 1);
   localparam logic [GAP_W-1:0] GAP_LOAD   = GAP_W'(GAP_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_HOLD  = 3'd3,
      S_GAP   = 3'd4
   } state_t;

   state_t                      state_q, state_d;
   logic [NUM_REQUESTERS-1:0]   grant_q, grant_d;
   logic [NUM_REQUESTERS-1:0]   ack_q, ack_d;
   logic [IDX_W-1:0]            owner_q, owner_d;
   logic [IDX_W-1:0]            last_q, last_d;
   logic [CS_INDEX_WIDTH-1:0]   cs_index_q, cs_index_d;
   logic                        cs_hold_q, cs_hold_d;
   logic [7:0]                  tx_q, tx_d;
   logic [7:0]                  rx_q, rx_d;
   logic                        last_flag_q, last_flag_d;
   logic [GAP_W-1:0]            gap_q, gap_d;
   logic                        start_s;

   logic                        arb_found_s;
   logic [IDX_W-1:0]            arb_idx_s;
   logic [CS_INDEX_WIDTH-1:0]   arb_cs_s;
   logic [7:0]                  owner_tx_s;

   // Round-robin search: first requesting index after the previous owner, with wrap.
   always_comb begin
      int               cand;
      logic [IDX_W-1:0] cand_idx;
      cand        = 0;
      cand_idx    = '0;
      arb_found_s = 1'b0;
      arb_idx_s   = '0;
      for (int k = 1; k <= NUM_REQUESTERS; k++) begin
         cand     = (int'(last_q) + k) % NUM_REQUESTERS;
         cand_idx = IDX_W'(cand);
         if (!arb_found_s && req[cand_idx]) begin
            arb_found_s = 1'b1;
            arb_idx_s   = cand_idx;
         end else begin
            arb_found_s = arb_found_s;
         end
      end
   end

   // Select the winner's CS line and the owner's transmit byte from the packed buses.
   always_comb begin
      arb_cs_s   = '0;
      owner_tx_s = 8'h00;
      for (int i = 0; i < NUM_REQUESTERS; i++) begin
         if (arb_idx_s == IDX_W'(i)) begin
            arb_cs_s = req_cs_index[i*CS_INDEX_WIDTH +: CS_INDEX_WIDTH];
         end else begin
            arb_cs_s = arb_cs_s;
         end
         if (owner_q == IDX_W'(i)) begin
            owner_tx_s = req_tx_data[i*8 +: 8];
         end else begin
            owner_tx_s = owner_tx_s;
         end
      end
   end

   // Next-state and output logic of the arbitration FSM.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      ack_d       = '0;
      owner_d     = owner_q;
      last_d      = last_q;
      cs_index_d  = cs_index_q;
      cs_hold_d   = cs_hold_q;
      tx_d        = tx_q;
      rx_d        = rx_q;
      last_flag_d = last_flag_q;
      gap_d       = gap_q;
      start_s     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (arb_found_s) begin
               grant_d            = '0;
               grant_d[arb_idx_s] = 1'b1;
               owner_d            = arb_idx_s;
               last_d             = arb_idx_s;
               cs_index_d         = arb_cs_s;
               cs_hold_d          = 1'b1;
               state_d            = S_ISSUE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ISSUE: begin
            // The controller may still be finishing earlier work; never start over it.
            if (!spi_busy) begin
               start_s     = 1'b1;
               tx_d        = owner_tx_s;
               last_flag_d = req_last[owner_q];
               state_d     = S_WAIT;
            end else begin
               state_d = S_ISSUE;
            end
         end
         S_WAIT: begin
            if (spi_done) begin
               ack_d[owner_q] = 1'b1;
               rx_d           = spi_rx_data;
               if (last_flag_q) begin
                  grant_d    = '0;
                  cs_hold_d  = 1'b0;
                  cs_index_d = '0;
                  tx_d       = 8'h00;
                  gap_d      = GAP_LOAD;
                  state_d    = S_GAP;
               end else begin
                  state_d = S_HOLD;
               end
            end else begin
               state_d = S_WAIT;
            end
         end
         S_HOLD: begin
            // Only the owner matters here; a dropped request also closes the burst.
            if (req[owner_q]) begin
               state_d = S_ISSUE;
            end else begin
               grant_d    = '0;
               cs_hold_d  = 1'b0;
               cs_index_d = '0;
               tx_d       = 8'h00;
               gap_d      = GAP_LOAD;
               state_d    = S_GAP;
            end
         end
         S_GAP: begin
            if (gap_q <= 4'd1) begin
               gap_d   = 4'd0;
               state_d = S_IDLE;
            end else begin
               gap_d   = gap_q - 4'd1;
               state_d = S_GAP;
            end
         end
         default: begin
            grant_d   = '0;
            cs_hold_d = 1'b0;
            gap_d     = 4'd0;
            state_d   = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any transfer in progress.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         grant_q     <= '0;
         ack_q       <= '0;
         owner_q     <= '0;
         last_q      <= LAST_RESET;
         cs_index_q  <= '0;
         cs_hold_q   <= 1'b0;
         tx_q        <= 8'h00;
         rx_q        <= 8'h00;
         last_flag_q <= 1'b0;
         gap_q       <= 4'd0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         ack_q       <= ack_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         cs_index_q  <= cs_index_d;
         cs_hold_q   <= cs_hold_d;
         tx_q        <= tx_d;
         rx_q        <= rx_d;
         last_flag_q <= last_flag_d;
         gap_q       <= gap_d;
      end
   end

   assign grant        = grant_q;
   assign ack          = ack_q;
   assign rx_data      = rx_q;
   assign spi_start    = start_s;
   // The start cycle presents the live byte; afterwards the latched copy holds it stable.
   assign spi_tx_data  = start_s ? owner_tx_s : tx_q;
   assign spi_cs_index = cs_index_q;
   assign spi_cs_hold  = cs_hold_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Self-checking bench for spi_bus_arbiter (2 requesters, 1-bit CS index, gap 2).
// A small controller model answers each spi_start with busy for 2 cycles and
// a spi_done on the 3rd, returning the transmitted byte as the received byte.
module tb_spi_bus_arbiter;

   logic        clock;
   logic        reset;
   logic [1:0]  req;
   logic [1:0]  req_last;
   logic [15:0] req_tx_data;
   logic [1:0]  req_cs_index;
   logic [1:0]  grant;
   logic [1:0]  ack;
   logic [7:0]  rx_data;
   logic        spi_start;
   logic [7:0]  spi_tx_data;
   logic [0:0]  spi_cs_index;
   logic        spi_cs_hold;
   logic        spi_busy;
   logic        spi_done;
   logic [7:0]  spi_rx_data;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int ctl_cnt  = 0;
   int stall_left  = 0;
   int start_count = 0;
   logic [7:0] ctl_rx = 8'h00;

   spi_bus_arbiter #(
      .NUM_REQUESTERS(2),
      .CS_INDEX_WIDTH(1),
      .GAP_CYCLES(2)
   ) dut (
      .clock(clock),
      .reset(reset),
      .req(req),
      .req_last(req_last),
      .req_tx_data(req_tx_data),
      .req_cs_index(req_cs_index),
      .grant(grant),
      .ack(ack),
      .rx_data(rx_data),
      .spi_start(spi_start),
      .spi_tx_data(spi_tx_data),
      .spi_cs_index(spi_cs_index),
      .spi_cs_hold(spi_cs_hold),
      .spi_busy(spi_busy),
      .spi_done(spi_done),
      .spi_rx_data(spi_rx_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [1:0] req;
      logic [1:0] last;
      logic [1:0] grant;
      logic       hold;
      logic       start;
      logic [7:0] tx;
      logic [1:0] ack;
      logic [7:0] rx;
   } vec_t;

   vec_t tbl [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock cycle: drive controller inputs after the edge, then sample outputs.
   task automatic cycle();
      @(posedge clock);
      #1;
      cyc++;
      if (ctl_cnt > 0) begin
         ctl_cnt--;
         spi_busy    = (ctl_cnt != 0);
         spi_done    = (ctl_cnt == 0);
         spi_rx_data = (ctl_cnt == 0) ? ctl_rx : 8'h00;
      end else begin
         spi_busy = (stall_left > 0);
         if (stall_left > 0) stall_left--;
         spi_done    = 1'b0;
         spi_rx_data = 8'h00;
      end
      #1;
      if (spi_start) begin
         start_count++;
         chk("start_while_busy", 32'(spi_busy), 32'd0);
         ctl_cnt = 3;
         ctl_rx  = spi_tx_data;
      end
      if (ack != 2'b00) chk("ack_onehot", 32'($countones(ack)), 32'd1);
   endtask

   task automatic do_reset();
      reset       = 1'b0;
      req         = 2'b00;
      req_last    = 2'b00;
      ctl_cnt     = 0;
      stall_left  = 0;
      spi_busy    = 1'b0;
      spi_done    = 1'b0;
      spi_rx_data = 8'h00;
      repeat (2) @(posedge clock);
      #3 reset = 1'b1;
   endtask

   initial begin
      bit         got;
      int         ng;
      int         low;
      int         done_cyc;
      logic [1:0] prevg;
      logic [1:0] fexp [4];
      logic [7:0] bvals [3];

      req_tx_data  = 16'h0000;
      req_cs_index = 2'b00;
      fexp[0] = 2'b01; fexp[1] = 2'b10; fexp[2] = 2'b01; fexp[3] = 2'b10;
      bvals[0] = 8'h11; bvals[1] = 8'h22; bvals[2] = 8'h33;

      //                req    last   grant  hold  start tx     ack    rx
      tbl[0] = '{2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 8'h00};
      tbl[1] = '{2'b01, 2'b01, 2'b01, 1'b1, 1'b1, 8'hA5, 2'b00, 8'h00};
      tbl[2] = '{2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 8'hA5, 2'b00, 8'h00};
      tbl[3] = '{2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 8'hA5, 2'b00, 8'h00};
      tbl[4] = '{2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 8'hA5, 2'b00, 8'h00};
      tbl[5] = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b01, 8'hA5};
      tbl[6] = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 8'hA5};
      tbl[7] = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 8'hA5};
      tbl[8] = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00, 8'hA5};

      // Reset state
      do_reset();
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_start", 32'(spi_start), 32'd0);
      chk("rst_hold", 32'(spi_cs_hold), 32'd0);
      chk("rst_tx", 32'(spi_tx_data), 32'd0);
      chk("rst_cs", 32'(spi_cs_index), 32'd0);
      chk("rst_rx", 32'(rx_data), 32'd0);

      // Single byte, table-driven per cycle
      req_tx_data = 16'h00A5;
      for (int i = 0; i < 9; i++) begin
         cycle();
         chk("sb_grant", 32'(grant), 32'(tbl[i].grant));
         chk("sb_hold", 32'(spi_cs_hold), 32'(tbl[i].hold));
         chk("sb_start", 32'(spi_start), 32'(tbl[i].start));
         chk("sb_ack", 32'(ack), 32'(tbl[i].ack));
         chk("sb_rx", 32'(rx_data), 32'(tbl[i].rx));
         if (tbl[i].grant != 2'b00) begin
            chk("sb_tx", 32'(spi_tx_data), 32'(tbl[i].tx));
            chk("sb_cs", 32'(spi_cs_index), 32'd0);
         end
         req      = tbl[i].req;
         req_last = tbl[i].last;
      end

      // Burst of 3 from requester 1 on CS line 1
      do_reset();
      req_cs_index = 2'b10;
      req          = 2'b10;
      done_cyc     = 0;
      for (int b = 0; b < 3; b++) begin
         req_tx_data[15:8] = bvals[b];
         req_last          = (b == 2) ? 2'b10 : 2'b00;
         got = 1'b0;
         for (int i = 0; i < 20 && !got; i++) begin
            cycle();
            got = spi_start;
         end
         chk("burst_start_seen", 32'(got), 32'd1);
         chk("burst_tx", 32'(spi_tx_data), 32'(bvals[b]));
         chk("burst_cs", 32'(spi_cs_index), 32'd1);
         chk("burst_grant", 32'(grant), 32'd2);
         if (b > 0) chk("burst_restart_delay", 32'(cyc - done_cyc), 32'd2);
         got = 1'b0;
         for (int i = 0; i < 20 && !got; i++) begin
            cycle();
            got = (ack != 2'b00);
            if (!got) chk("burst_hold", 32'(spi_cs_hold), 32'd1);
         end
         chk("burst_ack_seen", 32'(got), 32'd1);
         chk("burst_ack", 32'(ack), 32'd2);
         chk("burst_rx", 32'(rx_data), 32'(bvals[b]));
         chk("burst_hold_at_ack", 32'(spi_cs_hold), (b < 2) ? 32'd1 : 32'd0);
         done_cyc = cyc - 1;
         if (b == 2) req = 2'b00;
      end

      // Fairness with both requests held and single-byte bursts
      do_reset();
      req_tx_data = 16'h0201;
      req         = 2'b11;
      req_last    = 2'b11;
      ng    = 0;
      low   = 0;
      prevg = 2'b00;
      for (int i = 0; i < 200 && ng < 4; i++) begin
         cycle();
         if (grant != 2'b00 && prevg == 2'b00) begin
            chk("fair_grant", 32'(grant), 32'(fexp[ng]));
            if (ng > 0) chk("fair_cs_gap", 32'(low), 32'd3);
            ng++;
            low = 0;
         end
         if (!spi_cs_hold) low++;
         prevg = grant;
      end
      chk("fair_grant_count", 32'(ng), 32'd4);

      // Busy stall: controller busy for 5 cycles starting with the grant cycle
      do_reset();
      req_tx_data = 16'h005A;
      req         = 2'b01;
      req_last    = 2'b01;
      stall_left  = 5;
      start_count = 0;
      for (int i = 1; i <= 6; i++) begin
         cycle();
         chk("stall_grant", 32'(grant), 32'd1);
         chk("stall_start", 32'(spi_start), (i == 6) ? 32'd1 : 32'd0);
      end
      cycle();
      chk("stall_single_start", 32'(start_count), 32'd1);
      chk("stall_tx", 32'(spi_tx_data), 32'h5A);

      // Dropped request ends the burst; pending requester 1 wins next
      do_reset();
      req_tx_data = 16'h0201;
      req         = 2'b11;
      req_last    = 2'b00;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         cycle();
         got = (ack != 2'b00);
      end
      chk("drop_ack_seen", 32'(got), 32'd1);
      chk("drop_ack", 32'(ack), 32'd1);
      chk("drop_hold_grant", 32'(grant), 32'd1);
      req = 2'b10;
      cycle();
      chk("drop_gap_grant", 32'(grant), 32'd0);
      chk("drop_gap_hold", 32'(spi_cs_hold), 32'd0);
      chk("drop_gap_start", 32'(spi_start), 32'd0);
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         cycle();
         got = (grant != 2'b00);
      end
      chk("drop_next_seen", 32'(got), 32'd1);
      chk("drop_next_grant", 32'(grant), 32'd2);

      // Asynchronous reset in the middle of a transfer
      do_reset();
      req_tx_data = 16'h00C3;
      req         = 2'b01;
      req_last    = 2'b01;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         cycle();
         got = spi_start;
      end
      chk("arst_start_seen", 32'(got), 32'd1);
      cycle();
      chk("arst_pre_grant", 32'(grant), 32'd1);
      #1;
      reset = 1'b0;
      req   = 2'b00;
      #1;
      chk("arst_grant", 32'(grant), 32'd0);
      chk("arst_start", 32'(spi_start), 32'd0);
      chk("arst_hold", 32'(spi_cs_hold), 32'd0);
      cycle();
      #1 reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("arst_no_ack", 32'(ack), 32'd0);
      end
      req      = 2'b11;
      req_last = 2'b11;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         cycle();
         got = (grant != 2'b00);
      end
      chk("arst_regrant_seen", 32'(got), 32'd1);
      chk("arst_regrant", 32'(grant), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
